// File: rtl/timer_irq_unit_pkg.sv
// Shared register map and TCON bit positions for the timer/interrupt peripheral.
package timer_irq_unit_pkg;

    // Byte offsets of the registers inside the 16-byte window.
    localparam logic [3:0] TH_OFF      = 4'h0;
    localparam logic [3:0] TL_OFF      = 4'h4;
    localparam logic [3:0] TCON_OFF    = 4'h8;
    localparam logic [3:0] SYSTICK_OFF = 4'hC;

    // TCON bit positions.
    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int IS_BIT = 2;

    // Byte offset of the word selected by addr[3:2]; byte lanes are ignored.
    function automatic logic [3:0] word_off(input logic [1:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage

// File: rtl/timer_irq_unit_tick_prescaler.sv
// Divides clk into one-cycle timer ticks, one every PRESCALE cycles while enabled.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pc;

    assign tick = en && (pc == LAST);

    // Count 0..PRESCALE-1 while enabled; parked at 0 when disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (!en || tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped reload timer with level interrupt and free-running tick counter.
module timer_irq_unit
    import timer_irq_unit_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter int          PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        en;
    logic        ie;
    logic        is;
    logic        en_next;
    logic        ie_next;
    logic        is_next;
    logic        tick;
    logic        overflow;
    logic        hit;
    logic [3:0]  off;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        unused_addr_bits;

    assign hit              = (addr[31:4] == BASE[31:4]);
    assign off              = word_off(addr[3:2]);
    assign unused_addr_bits = ^addr[1:0];

    assign wr_th   = wr && hit && (off == TH_OFF);
    assign wr_tl   = wr && hit && (off == TL_OFF);
    assign wr_tcon = wr && hit && (off == TCON_OFF);

    // A CPU write to TL swallows a coincident tick, so no overflow either.
    assign overflow = tick && !wr_tl && (tl == 32'hFFFF_FFFF);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    // Next TCON state: software update first, then overflow set has priority over W1C.
    always_comb begin
        en_next = en;
        ie_next = ie;
        is_next = is;
        if (wr_tcon) begin
            en_next = wdata[EN_BIT];
            ie_next = wdata[IE_BIT];
            if (wdata[IS_BIT]) begin
                is_next = 1'b0;
            end
        end
        if (overflow) begin
            is_next = 1'b1;
        end
    end

    // Register file, timer count/reload, system tick and registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            systick <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            is      <= 1'b0;
            irqout  <= 1'b0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end else if (tick) begin
                tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
            end
            en     <= en_next;
            ie     <= ie_next;
            is     <= is_next;
            irqout <= is_next & ie_next;
        end
    end

    // Zero-latency read mux; zero unless a read hits the window.
    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (off)
                TH_OFF:      rdata = th;
                TL_OFF:      rdata = tl;
                TCON_OFF:    rdata = {29'd0, is, ie, en};
                SYSTICK_OFF: rdata = systick;
                default:     rdata = '0;
            endcase
        end
    end

endmodule
